mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 256x8 map/LED memory between the CPU core (port A) and an auxiliary master (port B, e.g. display scanner or host loader). It sits directly in front of the memory, drives its we/in/addr, and returns registered read data per requester. Round-robin policy with an optional bounded lock (burst ownership) so a requester can do read-modify-write or table walks atomically.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arb_rsp.sv | 31 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the map/LED memory arbiter.
// Holds the arbiter state encoding, port ids and the memory map layout.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int MAP_INDEX_BASE = 33;
    localparam int AREA_BASE      = 67;
    localparam int LED_BASE       = 215;
    localparam int NUM_AREAS      = 33;

endpackage

// File: rtl/mem_arb_rsp.sv
// Per-port read return: captures memory read data at the end of an accepted
// read beat and pulses o_rvalid for one cycle; data holds until the next read.
module mem_arb_rsp #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_capture,
    input  logic [DW-1:0] i_rdata,
    output logic          o_rvalid,
    output logic [DW-1:0] o_rdata
);

    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= i_capture;
            if (i_capture)
                r_rdata <= i_rdata;
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port map/LED memory,
// with bounded locked bursts so one master can run atomic sequences.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW:0] BURST_LIM = MAX_BURST[CW:0];

    arb_state_t  r_state;
    logic        r_last_grant;
    logic [CW-1:0] r_burst_cnt;

    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_lock;
    logic          w_cont;
    logic [CW:0]   w_beats;

    // Owner keeps the memory only while it keeps requesting; otherwise round-robin.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst_n) begin
            w_gnt_a = 1'b0;
        end else if (r_state == ST_OWN_A && a_req) begin
            w_gnt_a = 1'b1;
        end else if (r_state == ST_OWN_B && b_req) begin
            w_gnt_b = 1'b1;
        end else if (a_req && b_req) begin
            w_gnt_a = (r_last_grant == PORT_B);
            w_gnt_b = (r_last_grant == PORT_A);
        end else begin
            w_gnt_a = a_req;
            w_gnt_b = b_req;
        end
    end

    // A burst continues counting only when the current owner gets the beat.
    assign w_cont  = (w_gnt_a && r_state == ST_OWN_A) || (w_gnt_b && r_state == ST_OWN_B);
    assign w_beats = (w_cont ? {1'b0, r_burst_cnt} : '0) + 1'b1;
    assign w_lock  = w_gnt_a ? a_lock : b_lock;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_B;
            r_burst_cnt  <= '0;
        end else if (w_gnt_a || w_gnt_b) begin
            r_last_grant <= w_gnt_a ? PORT_A : PORT_B;
            if (w_lock && (w_beats < BURST_LIM)) begin
                r_state     <= w_gnt_a ? ST_OWN_A : ST_OWN_B;
                r_burst_cnt <= w_beats[CW-1:0];
            end else begin
                r_state     <= ST_IDLE;
                r_burst_cnt <= '0;
            end
        end else begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
        end
    end

    assign a_gnt     = w_gnt_a;
    assign b_gnt     = w_gnt_b;
    assign mem_we    = (w_gnt_a & a_we) | (w_gnt_b & b_we);
    assign mem_addr  = w_gnt_a ? a_addr  : (w_gnt_b ? b_addr  : '0);
    assign mem_wdata = w_gnt_a ? a_wdata : (w_gnt_b ? b_wdata : '0);

    mem_arb_rsp #(.DW(DW)) u_rsp_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_gnt_a & ~a_we),
        .i_rdata   (mem_rdata),
        .o_rvalid  (a_rvalid),
        .o_rdata   (a_rdata)
    );

    mem_arb_rsp #(.DW(DW)) u_rsp_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_gnt_b & ~b_we),
        .i_rdata   (mem_rdata),
        .o_rvalid  (b_rvalid),
        .o_rdata   (b_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 memory behind it.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic exp_rr_a [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_bst_a [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[MAP_INDEX_BASE] = 8'(AREA_BASE);
        mem[LED_BASE]       = 8'hC0;
        mem[LED_BASE + 1]   = 8'hF9;

        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_lock = 1'b0; a_addr = 8'd5; a_wdata = 8'd9;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = 8'd0; b_wdata = 8'd0;

        // Requests during reset are never granted and never write.
        sample();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        next_cyc();
        rst_n = 1'b1; a_req = 1'b0; a_we = 1'b0;
        sample();
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_b_rvalid", b_rvalid, 0);

        // Single read of the map index
        next_cyc();
        a_req = 1'b1; a_addr = 8'(MAP_INDEX_BASE);
        sample();
        check("t1_a_gnt", a_gnt, 1);
        check("t1_b_gnt", b_gnt, 0);
        check("t1_mem_addr", mem_addr, MAP_INDEX_BASE);
        next_cyc();
        a_req = 1'b0;
        sample();
        check("t1_a_rvalid", a_rvalid, 1);
        check("t1_a_rdata", a_rdata, AREA_BASE);
        check("t1_b_rvalid", b_rvalid, 0);
        check("t1_b_rdata", b_rdata, 0);
        check("t1_idle_addr", mem_addr, 0);
        next_cyc();
        sample();
        check("t1_a_rvalid_pulse", a_rvalid, 0);
        check("t1_a_rdata_hold", a_rdata, AREA_BASE);

        // Contention without lock; A was granted last so B goes first
        next_cyc();
        a_req = 1'b1; a_addr = 8'(LED_BASE);
        b_req = 1'b1; b_addr = 8'(LED_BASE + 1);
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("rr_a_gnt%0d", i), a_gnt, exp_rr_a[i]);
            check($sformatf("rr_b_gnt%0d", i), b_gnt, !exp_rr_a[i]);
            if (i > 0) check($sformatf("rr_a_rvalid%0d", i), a_rvalid, exp_rr_a[i-1]);
            next_cyc();
        end
        a_req = 1'b0; b_req = 1'b0;
        sample();
        check("rr_a_rvalid_last", a_rvalid, 1);
        check("rr_a_rdata", a_rdata, 8'hC0);
        check("rr_b_rdata", b_rdata, 8'hF9);

        // A writes, B reads the same location back
        next_cyc();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'd5; a_wdata = 8'd3;
        sample();
        check("wr_a_gnt", a_gnt, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 5);
        check("wr_mem_wdata", mem_wdata, 3);
        next_cyc();
        a_req = 1'b0; a_we = 1'b0;
        b_req = 1'b1; b_addr = 8'd5;
        sample();
        check("wr_b_gnt", b_gnt, 1);
        check("wr_a_rvalid", a_rvalid, 0);
        check("wr_mem_we_rd", mem_we, 0);
        next_cyc();
        b_req = 1'b0;
        sample();
        check("wr_b_rvalid", b_rvalid, 1);
        check("wr_b_rdata", b_rdata, 3);

        // Locked bursts of A cap at four beats, then B gets a turn
        next_cyc();
        a_req = 1'b1; a_lock = 1'b1; a_addr = 8'(MAP_INDEX_BASE);
        b_req = 1'b1; b_addr = 8'(LED_BASE + 1);
        for (int i = 0; i < 10; i++) begin
            sample();
            check($sformatf("bst_a_gnt%0d", i), a_gnt, exp_bst_a[i]);
            check($sformatf("bst_b_gnt%0d", i), b_gnt, !exp_bst_a[i]);
            next_cyc();
        end
        a_req = 1'b0; a_lock = 1'b0; b_req = 1'b0;
        sample();
        next_cyc();

        // A locks, then drops its request after two beats
        a_req = 1'b1; a_lock = 1'b1; b_req = 1'b1;
        sample();
        check("drop_a_gnt0", a_gnt, 1);
        next_cyc();
        sample();
        check("drop_a_gnt1", a_gnt, 1);
        check("drop_b_gnt1", b_gnt, 0);
        next_cyc();
        a_req = 1'b0;
        sample();
        check("drop_b_gnt2", b_gnt, 1);
        check("drop_a_gnt2", a_gnt, 0);
        next_cyc();
        b_req = 1'b0; a_lock = 1'b0;
        sample();
        check("drop_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("drop_cnt", 32'(dut.r_burst_cnt), 0);
        check("drop_b_rdata", b_rdata, 8'hF9);

        // Reset in the middle of a locked read burst
        next_cyc();
        mem[MAP_INDEX_BASE] = 8'(AREA_BASE);
        a_req = 1'b1; a_lock = 1'b1; a_addr = 8'(MAP_INDEX_BASE);
        sample();
        check("mid_a_gnt0", a_gnt, 1);
        next_cyc();
        sample();
        check("mid_a_gnt1", a_gnt, 1);
        next_cyc();
        sample();
        check("mid_state", 32'(dut.r_state), 32'(ST_OWN_A));
        check("mid_cnt", 32'(dut.r_burst_cnt), 2);
        check("mid_a_rdata", a_rdata, AREA_BASE);
        next_cyc();
        rst_n = 1'b0; b_req = 1'b1; b_addr = 8'(LED_BASE);
        sample();
        check("mid_rst_a_gnt", a_gnt, 0);
        check("mid_rst_b_gnt", b_gnt, 0);
        next_cyc();
        rst_n = 1'b1; a_lock = 1'b0;
        sample();
        check("post_rst_a_rvalid", a_rvalid, 0);
        check("post_rst_a_rdata", a_rdata, 0);
        check("post_rst_b_rdata", b_rdata, 0);
        check("post_rst_a_gnt", a_gnt, 1);
        check("post_rst_b_gnt", b_gnt, 0);
        next_cyc();
        a_req = 1'b0; b_req = 1'b0;
        sample();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
